// File: rtl/pet_pkg.sv
// Shared definitions for the PET .PRG loader: loader FSM states and RAM map constants.
package pet_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    DATA   = 3'd3,
    PATCH  = 3'd4,
    DONE   = 3'd5
  } prg_state_t;

  localparam logic [15:0] PET_RAM_TOP = 16'h8000;
  localparam logic [14:0] PET_VARTAB  = 15'h002A;

endpackage

// File: rtl/pet_prg_injector.sv
// Streams a host .PRG image into PET main RAM over the DMA port, then fixes up
// VARTAB/ARYTAB/STREND so the loaded BASIC program can be RUN immediately.
module pet_prg_injector
  import pet_pkg::*;
#(
  parameter bit          PATCH_EN   = 1'b1,
  parameter logic [14:0] PATCH_BASE = PET_VARTAB,
  parameter logic [15:0] RAM_TOP    = PET_RAM_TOP
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic [14:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic        overflow
);

  prg_state_t  r_state;
  logic        r_dl_active_d;
  logic [15:0] r_cur_addr;
  logic [14:0] r_dma_addr;
  logic [7:0]  r_dma_din;
  logic        r_dma_we;
  logic        r_cpu_hold;
  logic        r_load_done;
  logic        r_load_err;
  logic        r_overflow;
  logic [2:0]  r_patch_cnt;

  prg_state_t  w_state_next;
  logic [15:0] w_cur_addr_next;
  logic [14:0] w_dma_addr_next;
  logic [7:0]  w_dma_din_next;
  logic        w_dma_we_next;
  logic        w_cpu_hold_next;
  logic        w_load_done_next;
  logic        w_load_err_next;
  logic        w_overflow_next;
  logic [2:0]  w_patch_cnt_next;

  logic        w_rise;
  logic        w_accept;
  logic [15:0] w_end;

  assign w_rise = dl_active & ~r_dl_active_d;
  // A strobe landing on the falling-edge cycle still belongs to the payload.
  assign w_accept = dl_wr & (dl_active | r_dl_active_d);
  assign w_end = (r_cur_addr >= RAM_TOP) ? RAM_TOP : r_cur_addr;

  always_comb begin
    w_state_next     = r_state;
    w_cur_addr_next  = r_cur_addr;
    w_dma_addr_next  = r_dma_addr;
    w_dma_din_next   = r_dma_din;
    w_dma_we_next    = 1'b0;
    w_cpu_hold_next  = r_cpu_hold;
    w_load_done_next = 1'b0;
    w_load_err_next  = r_load_err;
    w_overflow_next  = r_overflow;
    w_patch_cnt_next = r_patch_cnt;

    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_load_err_next = 1'b0;
          w_overflow_next = 1'b0;
          w_cpu_hold_next = 1'b1;
          w_state_next    = HDR_LO;
        end
      end
      HDR_LO: begin
        if (!dl_active) begin
          w_load_err_next = 1'b1;
          w_cpu_hold_next = 1'b0;
          w_state_next    = IDLE;
        end else if (dl_wr) begin
          w_cur_addr_next = {r_cur_addr[15:8], dl_data};
          w_state_next    = HDR_HI;
        end
      end
      HDR_HI: begin
        if (!dl_active) begin
          w_load_err_next = 1'b1;
          w_cpu_hold_next = 1'b0;
          w_state_next    = IDLE;
        end else if (dl_wr) begin
          w_cur_addr_next = {dl_data, r_cur_addr[7:0]};
          w_state_next    = DATA;
        end
      end
      DATA: begin
        if (w_accept) begin
          if (r_cur_addr >= RAM_TOP) begin
            w_overflow_next = 1'b1;
            w_cur_addr_next = RAM_TOP;
          end else begin
            w_dma_we_next   = 1'b1;
            w_dma_addr_next = r_cur_addr[14:0];
            w_dma_din_next  = dl_data;
            w_cur_addr_next = r_cur_addr + 16'd1;
          end
        end
        if (!dl_active) begin
          w_patch_cnt_next = 3'd0;
          w_state_next     = PATCH_EN ? PATCH : DONE;
        end
      end
      PATCH: begin
        // Even slots carry the low byte, odd slots the high byte of the end pointer.
        w_dma_we_next    = 1'b1;
        w_dma_addr_next  = PATCH_BASE + {12'd0, r_patch_cnt};
        w_dma_din_next   = r_patch_cnt[0] ? w_end[15:8] : w_end[7:0];
        w_patch_cnt_next = r_patch_cnt + 3'd1;
        if (r_patch_cnt == 3'd5) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_load_done_next = 1'b1;
        w_cpu_hold_next  = 1'b0;
        w_state_next     = IDLE;
      end
      default: begin
        w_cpu_hold_next = 1'b0;
        w_state_next    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_dl_active_d <= 1'b0;
      r_cur_addr    <= 16'd0;
      r_dma_addr    <= 15'd0;
      r_dma_din     <= 8'd0;
      r_dma_we      <= 1'b0;
      r_cpu_hold    <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
      r_overflow    <= 1'b0;
      r_patch_cnt   <= 3'd0;
    end else begin
      r_state       <= w_state_next;
      r_dl_active_d <= dl_active;
      r_cur_addr    <= w_cur_addr_next;
      r_dma_addr    <= w_dma_addr_next;
      r_dma_din     <= w_dma_din_next;
      r_dma_we      <= w_dma_we_next;
      r_cpu_hold    <= w_cpu_hold_next;
      r_load_done   <= w_load_done_next;
      r_load_err    <= w_load_err_next;
      r_overflow    <= w_overflow_next;
      r_patch_cnt   <= w_patch_cnt_next;
    end
  end

  assign dma_addr  = r_dma_addr;
  assign dma_din   = r_dma_din;
  assign dma_we    = r_dma_we;
  assign cpu_hold  = r_cpu_hold;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_pet_prg_injector.sv
// Directed bench for pet_prg_injector: default instance plus a PATCH_EN=0 instance
// sharing the same host stimulus.
module tb_pet_prg_injector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dl_active;
  logic        dl_wr;
  logic [7:0]  dl_data;

  logic [14:0] dma_addr, np_addr;
  logic [7:0]  dma_din, np_din;
  logic        dma_we, np_we;
  logic        cpu_hold, np_hold;
  logic        load_done, np_done;
  logic        load_err, np_err;
  logic        overflow, np_ovf;

  int n_vec = 0;
  int n_err = 0;
  int n_we = 0;
  int n_done = 0;
  int n_np_patch = 0;

  always #5 clk = ~clk;

  pet_prg_injector dut (
    .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr), .dl_data(dl_data),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err), .overflow(overflow)
  );

  pet_prg_injector #(.PATCH_EN(1'b0)) dut_np (
    .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr), .dl_data(dl_data),
    .dma_addr(np_addr), .dma_din(np_din), .dma_we(np_we), .cpu_hold(np_hold),
    .load_done(np_done), .load_err(np_err), .overflow(np_ovf)
  );

  always @(negedge clk) begin
    if (dma_we) n_we++;
    if (load_done) n_done++;
    if (np_we && np_addr >= 15'h002A && np_addr <= 15'h002F) n_np_patch++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_dl(input string tag);
    @(negedge clk);
    dl_active = 1'b1;
    dl_wr = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_hold_on"}, {15'd0, cpu_hold}, 16'd1);
    chk({tag, "_err_clr"}, {15'd0, load_err}, 16'd0);
    chk({tag, "_ovf_clr"}, {15'd0, overflow}, 16'd0);
  endtask

  // One strobe; the write (if any) must be visible exactly one edge later.
  task automatic send_byte(input string tag, input logic [7:0] b,
                           input logic exp_we, input logic [14:0] exp_addr);
    @(negedge clk);
    dl_wr = 1'b1;
    dl_data = b;
    @(posedge clk); #1;
    chk({tag, "_we"}, {15'd0, dma_we}, {15'd0, exp_we});
    if (exp_we) begin
      chk({tag, "_addr"}, {1'b0, dma_addr}, {1'b0, exp_addr});
      chk({tag, "_din"}, {8'd0, dma_din}, {8'd0, b});
    end
  endtask

  task automatic end_and_patch(input string tag, input logic [15:0] e);
    logic [7:0] exp_b;
    @(negedge clk);
    dl_wr = 1'b0;
    dl_active = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_gap_we"}, {15'd0, dma_we}, 16'd0);
    for (int i = 0; i < 6; i++) begin
      exp_b = (i % 2 == 1) ? e[15:8] : e[7:0];
      @(posedge clk); #1;
      chk($sformatf("%s_p%0d_we", tag, i), {15'd0, dma_we}, 16'd1);
      chk($sformatf("%s_p%0d_addr", tag, i), {1'b0, dma_addr}, 16'h002A + 16'(i));
      chk($sformatf("%s_p%0d_din", tag, i), {8'd0, dma_din}, {8'd0, exp_b});
      chk($sformatf("%s_p%0d_hold", tag, i), {15'd0, cpu_hold}, 16'd1);
    end
    @(posedge clk); #1;
    chk({tag, "_done"}, {15'd0, load_done}, 16'd1);
    chk({tag, "_hold_off"}, {15'd0, cpu_hold}, 16'd0);
    chk({tag, "_done_we"}, {15'd0, dma_we}, 16'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {15'd0, load_done}, 16'd0);
    idle(10);
  endtask

  task automatic scenario1(input string tag);
    start_dl(tag);
    send_byte({tag, "_hlo"}, 8'h01, 1'b0, 15'd0);
    send_byte({tag, "_hhi"}, 8'h04, 1'b0, 15'd0);
    send_byte({tag, "_d0"}, 8'h0A, 1'b1, 15'h0401);
    send_byte({tag, "_d1"}, 8'h0B, 1'b1, 15'h0402);
    send_byte({tag, "_d2"}, 8'h0C, 1'b1, 15'h0403);
    end_and_patch(tag, 16'h0404);
    chk({tag, "_ovf"}, {15'd0, overflow}, 16'd0);
    chk({tag, "_err"}, {15'd0, load_err}, 16'd0);
  endtask

  initial begin
    int we_base;
    int done_base;
    reset_n = 1'b0;
    dl_active = 1'b0;
    dl_wr = 1'b0;
    dl_data = 8'h00;
    idle(3);
    #1;
    chk("rst_we", {15'd0, dma_we}, 16'd0);
    chk("rst_addr", {1'b0, dma_addr}, 16'd0);
    chk("rst_din", {8'd0, dma_din}, 16'd0);
    chk("rst_hold", {15'd0, cpu_hold}, 16'd0);
    chk("rst_done", {15'd0, load_done}, 16'd0);
    chk("rst_err", {15'd0, load_err}, 16'd0);
    chk("rst_ovf", {15'd0, overflow}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);

    // Strobe while not downloading must do nothing.
    we_base = n_we;
    send_byte("stray", 8'h55, 1'b0, 15'd0);
    @(negedge clk);
    dl_wr = 1'b0;
    idle(3);
    chk("stray_hold", {15'd0, cpu_hold}, 16'd0);
    chk("stray_nwe", 16'(n_we - we_base), 16'd0);

    scenario1("s1");

    // 256 back-to-back bytes at 0x1000.
    start_dl("s2");
    send_byte("s2_hlo", 8'h00, 1'b0, 15'd0);
    send_byte("s2_hhi", 8'h10, 1'b0, 15'd0);
    we_base = n_we;
    for (int i = 0; i < 256; i++) begin
      send_byte($sformatf("s2_b%0d", i), 8'(i) ^ 8'h5A, 1'b1, 15'h1000 + 15'(i));
    end
    end_and_patch("s2", 16'h1100);
    chk("s2_nwe", 16'(n_we - we_base), 16'd262);

    // Load at 7FFE: two bytes fit, two are dropped.
    start_dl("s3");
    send_byte("s3_hlo", 8'hFE, 1'b0, 15'd0);
    send_byte("s3_hhi", 8'h7F, 1'b0, 15'd0);
    send_byte("s3_d0", 8'h11, 1'b1, 15'h7FFE);
    send_byte("s3_d1", 8'h22, 1'b1, 15'h7FFF);
    chk("s3_ovf_pre", {15'd0, overflow}, 16'd0);
    send_byte("s3_d2", 8'h33, 1'b0, 15'd0);
    chk("s3_ovf_set", {15'd0, overflow}, 16'd1);
    send_byte("s3_d3", 8'h44, 1'b0, 15'd0);
    end_and_patch("s3", 16'h8000);
    chk("s3_ovf", {15'd0, overflow}, 16'd1);
    chk("s3_err", {15'd0, load_err}, 16'd0);

    // Download aborted inside the header.
    we_base = n_we;
    done_base = n_done;
    start_dl("s4");
    send_byte("s4_hlo", 8'h01, 1'b0, 15'd0);
    @(negedge clk);
    dl_wr = 1'b0;
    dl_active = 1'b0;
    @(posedge clk); #1;
    chk("s4_err", {15'd0, load_err}, 16'd1);
    chk("s4_hold", {15'd0, cpu_hold}, 16'd0);
    idle(10);
    chk("s4_nwe", 16'(n_we - we_base), 16'd0);
    chk("s4_ndone", 16'(n_done - done_base), 16'd0);
    chk("s4_err_sticky", {15'd0, load_err}, 16'd1);

    // Reset in the middle of DATA, with overflow already set.
    start_dl("s5");
    send_byte("s5_hlo", 8'hFF, 1'b0, 15'd0);
    send_byte("s5_hhi", 8'h7F, 1'b0, 15'd0);
    send_byte("s5_d0", 8'h11, 1'b1, 15'h7FFF);
    send_byte("s5_d1", 8'h22, 1'b0, 15'd0);
    chk("s5_ovf", {15'd0, overflow}, 16'd1);
    we_base = n_we;
    done_base = n_done;
    @(negedge clk);
    reset_n = 1'b0;
    dl_wr = 1'b1;
    dl_data = 8'h33;
    dl_active = 1'b0;
    @(posedge clk); #1;
    chk("s5_rst_we", {15'd0, dma_we}, 16'd0);
    chk("s5_rst_hold", {15'd0, cpu_hold}, 16'd0);
    chk("s5_rst_ovf", {15'd0, overflow}, 16'd0);
    chk("s5_rst_err", {15'd0, load_err}, 16'd0);
    chk("s5_rst_done", {15'd0, load_done}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dl_wr = 1'b0;
    idle(10);
    chk("s5_nwe", 16'(n_we - we_base), 16'd0);
    chk("s5_ndone", 16'(n_done - done_base), 16'd0);
    scenario1("s5r");

    // PATCH_EN=0 instance: one write, then straight to done.
    @(negedge clk);
    dl_active = 1'b1;
    @(posedge clk); #1;
    chk("s6_hold_on", {15'd0, np_hold}, 16'd1);
    @(negedge clk); dl_wr = 1'b1; dl_data = 8'h01;
    @(negedge clk); dl_data = 8'h04;
    @(negedge clk); dl_data = 8'hAA;
    @(posedge clk); #1;
    chk("s6_we", {15'd0, np_we}, 16'd1);
    chk("s6_addr", {1'b0, np_addr}, 16'h0401);
    chk("s6_din", {8'd0, np_din}, 16'h00AA);
    @(negedge clk);
    dl_wr = 1'b0;
    dl_active = 1'b0;
    @(posedge clk); #1;
    chk("s6_gap_we", {15'd0, np_we}, 16'd0);
    chk("s6_gap_done", {15'd0, np_done}, 16'd0);
    @(posedge clk); #1;
    chk("s6_done", {15'd0, np_done}, 16'd1);
    chk("s6_hold_off", {15'd0, np_hold}, 16'd0);
    chk("s6_done_we", {15'd0, np_we}, 16'd0);
    @(posedge clk); #1;
    chk("s6_done_pulse", {15'd0, np_done}, 16'd0);
    idle(12);
    chk("s6_no_patch", 16'(n_np_patch), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
